// File: rtl/pipeline_mem_pkg.sv
// pipeline_mem_pkg: shared types for the MEM stage.
// Size codes, FSM states, MEM/WB bundle and byte-count helper.
package pipeline_mem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_ACCESS = 2'b01,
    MEM_DONE   = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } mem_wb_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    logic [2:0] n;
    n = 3'd0;
    unique case (1'b1)
      size == MEM_BYTE: n = 3'd1;
      size == MEM_HALF: n = 3'd2;
      size == MEM_WORD: n = 3'd4;
      default:          n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipeline_mem_load_ext.sv
// mem_load_ext: extends an assembled load word by access size.
// Purely combinational; reusable by a future refill path.
module mem_load_ext
  import pipeline_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = data_i;
    unique case (1'b1)
      size_i == MEM_BYTE:
        ext_o = {{24{sign_i & data_i[7]}}, data_i[7:0]};
      size_i == MEM_HALF:
        ext_o = {{16{sign_i & data_i[15]}}, data_i[15:0]};
      default:
        ext_o = data_i;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// pipeline_mem: RV32I MEM stage, byte-serial loads/stores on an 8-bit port.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module pipeline_mem
  import pipeline_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        rd_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        mre_i,
  input  logic              mrsign_i,
  input  logic [1:0]        mwe_i,
  input  logic [DATA_W-1:0] mwdata_i,
  input  logic [ADDR_W-1:0] ma_i,
  input  logic [4:0]        stall_i,
  output logic [4:0]        rd_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  input  logic [7:0]        mem_din_i
);

  mem_state_e        state_q, state_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        cap_q, cap_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  mem_wb_t           wb_q, wb_d;

  logic              is_wr, is_rd, is_mem;
  logic              misal, misal_idle;
  logic [1:0]        size;
  logic [2:0]        nb;
  logic              issue, gnt, adv;
  logic              wr_last, rd_last;
  logic [DATA_W-1:0] ld_ext;
  logic [2:0]        unused_stall;

  assign unused_stall = stall_i[2:0];

  // A store wins when both request fields are set.
  assign is_wr  = |mwe_i;
  assign is_rd  = |mre_i && !is_wr;
  assign is_mem = is_wr || is_rd;
  assign size   = is_wr ? mwe_i : mre_i;
  assign nb     = size_bytes(size);
  assign adv    = !stall_i[3] && !stall_i[4];

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = is_mem &&
    ((size == MEM_HALF && ma_i[0]) ||
     (size == MEM_WORD && |ma_i[1:0]));
  assign misalign_o = rdy && !rst && misal_idle;
`else
  assign misal = 1'b0;
`endif

  assign misal_idle = (state_q == MEM_IDLE) && misal;

  mem_load_ext u_ext (
    .data_i (buf_q),
    .size_i (size),
    .sign_i (mrsign_i),
    .ext_o  (ld_ext)
  );

  always_comb begin
    stall_req_o = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        stall_req_o = is_mem && !misal;
        issue       = is_mem && !misal;
      end
      MEM_ACCESS: begin
        stall_req_o = 1'b1;
        issue       = iss_q < nb;
      end
      default: begin
        stall_req_o = 1'b0;
        issue       = 1'b0;
      end
    endcase
  end

  assign mem_req_o  = issue && rdy && !rst;
  assign mem_wr_o   = mem_req_o && is_wr;
  assign gnt        = mem_req_o && mem_gnt_i;
  assign mem_a_o    = mem_req_o
                    ? ma_i + ADDR_W'(iss_q)
                    : '0;
  assign mem_dout_o = mem_wr_o
                    ? mwdata_i[{iss_q[1:0], 3'b000} +: 8]
                    : 8'h00;

  // Store finishes on the last grant; load on the last capture.
  assign wr_last = gnt && (iss_q + 3'd1 == nb);
  assign rd_last = pend_q && (cap_q + 3'd1 == nb);

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    if (rdy) begin
      if (gnt) iss_d = iss_q + 3'd1;
      pend_d = gnt && !is_wr;
      if (pend_q) begin
        buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din_i;
        cap_d = cap_q + 3'd1;
      end
      unique case (state_q)
        MEM_IDLE: begin
          if (is_mem && !misal)
            state_d = (is_wr && wr_last)
                    ? MEM_DONE : MEM_ACCESS;
        end
        MEM_ACCESS: begin
          if (is_wr ? wr_last : rd_last)
            state_d = MEM_DONE;
        end
        MEM_DONE: begin
          if (adv) begin
            state_d = MEM_IDLE;
            iss_d   = 3'd0;
            cap_d   = 3'd0;
            pend_d  = 1'b0;
            buf_d   = '0;
          end
        end
        default: state_d = MEM_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (rdy && !stall_i[4]) begin
      if (stall_req_o || stall_i[3] || misal_idle) begin
        wb_d = '0;
      end else if (state_q == MEM_DONE) begin
        wb_d.rd    = rd_i;
        wb_d.we    = we_i && !is_wr;
        wb_d.wdata = is_rd ? ld_ext : wdata_i;
      end else begin
        wb_d.rd    = rd_i;
        wb_d.we    = we_i;
        wb_d.wdata = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      iss_q   <= 3'd0;
      cap_q   <= 3'd0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      wb_q    <= wb_d;
    end
  end

  assign rd_o    = wb_q.rd;
  assign we_o    = wb_q.we;
  assign wdata_o = wb_q.wdata;

  a_rw_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(|mre_i && |mwe_i)
  );

endmodule
